ahb_lite_master: RTL and testbench
==================================

// Module: ahb_lite_master
// PURPOSE
//   AHB-Lite initiator for the ahb_ifc bus: turns single read/write commands
//   from a valid/ready request port into pipelined AHB SINGLE transfers and
//   returns per-transfer read data/status. It drives the slave memories and
//   is the RTL initiator for the bus test harness.
// PARAMETERS
//   ADDR_WIDTH  32       HADDR / cmd_addr width
//   DATA_WIDTH  32       HWDATA / HRDATA / cmd_wdata / rsp_rdata width
//   HPROT_VAL   4'b0011  constant driven on HPROT (non-cacheable privileged data)
// PORTS
//   HCLK       in   1           bus clock, all state on rising edge
//   HRESETn    in   1           async active-low reset
//   cmd_valid  in   1           command request
//   cmd_ready  out  1           command accepted when cmd_valid && cmd_ready at HCLK edge
//   cmd_write  in   1           1=write, 0=read
//   cmd_addr   in   ADDR_WIDTH  byte address, caller aligns to cmd_size
//   cmd_size   in   3           HSIZE encoding, passed through unchanged
//   cmd_wdata  in   DATA_WIDTH  write data
//   rsp_valid  out  1           one-cycle pulse per completed transfer, no backpressure
//   rsp_rdata  out  DATA_WIDTH  HRDATA captured (reads); 0 for writes
//   rsp_error  out  1           1 = transfer ended with HRESP=ERROR
//   HADDR/HWRITE/HSIZE out      address-phase controls, registered
//   HTRANS     out  2           IDLE=2'b00 or NONSEQ=2'b10 only
//   HBURST     out  3           constant 3'b000 (SINGLE)
//   HPROT      out  4           constant HPROT_VAL
//   HWDATA     out  DATA_WIDTH  data-phase write data, registered
//   HRDATA     in   DATA_WIDTH; HREADY in 1; HRESP in 1 (0=OKAY, 1=ERROR)
// BEHAVIOUR
// - Reset (async, HRESETn low): HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=3'b010,
//   HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_error=0; addr/data-phase/replay state
//   cleared. Reset mid-transfer drops all outstanding work, no rsp for it.
// - Two pipeline stages: address-phase reg (A) drives HADDR/HTRANS/HWRITE/HSIZE;
//   data-phase reg (D) holds write flag + wdata of the transfer in data phase.
// - cmd_ready = HREADY && !replay_pend && !err_cancel (combinational).
// - Edge with HREADY=1: D <= A (if A NONSEQ), HWDATA <= A.wdata; A <= accepted cmd
//   with HTRANS=NONSEQ, else HTRANS=IDLE (HADDR etc. hold last value).
// - Edge with HREADY=0: A, D, HWDATA held stable (AHB hold rule).
// - Response: at edge with HREADY=1 and D valid, next cycle rsp_valid=1,
//   rsp_rdata=HRDATA (reads) / 0 (writes), rsp_error=HRESP. In order.
// - Latency, zero-wait: cmd accepted at edge E0 -> NONSEQ in cycle after E0 ->
//   data phase after E1 -> rsp_valid in cycle after E2. Throughput 1 xfer/cycle.
// - ERROR (two-cycle): edge sees HRESP=1 && HREADY=0 with D valid:
//   if A is NONSEQ, set HTRANS=IDLE (err_cancel=1), keep A fields, replay_pend=1.
//   Next edge (HREADY=1, HRESP=1): rsp for errored xfer as above; err_cancel=0.
//   Following edge: re-drive saved A as NONSEQ, replay_pend=0, cmd_ready resumes.
//   Error with A IDLE: no cancel, no replay; cmd_ready low during first error cycle.
// - HRESP=1 with HREADY=1 in first error cycle is treated as OKAY-completion with error
//   flag (protocol violation; no cancel).
// - cmd_write/cmd_size/cmd_addr are not checked; no retries beyond cancel replay.
// TESTING
// - Write addr 0x10 data 0xDEADBEEF, HREADY=1 -> one NONSEQ cycle HADDR=0x10 HWRITE=1,
//   HWDATA=0xDEADBEEF next cycle, rsp_valid 2 cycles after accept, rsp_error=0.
// - cmd_valid held for reads 0x10,0x14 -> NONSEQ in consecutive cycles, HADDR 0x14
//   overlaps 0x10 data phase; two rsp pulses in order with matching HRDATA.
// - Read 0x20, HREADY low 3 cycles in data phase, next cmd 0x24 queued -> HADDR=0x24
//   NONSEQ held stable, cmd_ready=0 throughout, rsp for 0x20 after HREADY rises.
// - Write 0x30 gets ERROR, read 0x34 in address phase -> HTRANS=IDLE in 2nd error
//   cycle, rsp_error=1 for write, then NONSEQ HADDR=0x34 reissued, rsp_error=0.
// - HRESETn low during wait-stated read -> all outputs at reset values immediately,
//   no rsp_valid; after release, write/read 0x40 0xA5A5A5A5 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: converts single read/write commands into pipelined SINGLE
// transfers (address stage A, data stage D) and returns in-order responses.
module ahb_lite_master #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    logic                  a_valid_reg;
    logic [ADDR_WIDTH-1:0] a_addr_reg;
    logic                  a_write_reg;
    logic [2:0]            a_size_reg;
    logic [DATA_WIDTH-1:0] a_wdata_reg;
    logic                  d_valid_reg;
    logic                  d_write_reg;
    logic [DATA_WIDTH-1:0] hwdata_reg;
    logic                  replay_pend_reg;
    logic                  err_cancel_reg;
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  rsp_error_reg;

    logic cmd_accept;
    logic err_cancel_start;

    assign cmd_ready  = HREADY && !replay_pend_reg && !err_cancel_reg;
    assign cmd_accept = cmd_valid && cmd_ready;

    // First cycle of a two-cycle ERROR while another transfer sits in address phase
    assign err_cancel_start = !HREADY && HRESP && d_valid_reg && a_valid_reg && !err_cancel_reg;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid_reg     <= 1'b0;
            a_addr_reg      <= '0;
            a_write_reg     <= 1'b0;
            a_size_reg      <= 3'b010;
            a_wdata_reg     <= '0;
            d_valid_reg     <= 1'b0;
            d_write_reg     <= 1'b0;
            hwdata_reg      <= '0;
            replay_pend_reg <= 1'b0;
            err_cancel_reg  <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_error_reg   <= 1'b0;
        end else if (HREADY) begin
            rsp_valid_reg <= d_valid_reg;
            if (d_valid_reg) begin
                rsp_rdata_reg <= d_write_reg ? '0 : HRDATA;
                rsp_error_reg <= HRESP;
            end
            d_valid_reg    <= a_valid_reg;
            d_write_reg    <= a_write_reg;
            hwdata_reg     <= a_wdata_reg;
            err_cancel_reg <= 1'b0;
            // The cancelled transfer kept its fields in A; it goes out again once the error has closed
            if (replay_pend_reg && !err_cancel_reg) begin
                a_valid_reg     <= 1'b1;
                replay_pend_reg <= 1'b0;
            end else if (cmd_accept) begin
                a_valid_reg <= 1'b1;
                a_addr_reg  <= cmd_addr;
                a_write_reg <= cmd_write;
                a_size_reg  <= cmd_size;
                a_wdata_reg <= cmd_wdata;
            end else begin
                a_valid_reg <= 1'b0;
            end
        end else begin
            rsp_valid_reg <= 1'b0;
            if (err_cancel_start) begin
                a_valid_reg     <= 1'b0;
                replay_pend_reg <= 1'b1;
                err_cancel_reg  <= 1'b1;
            end
        end
    end

    assign HADDR     = a_addr_reg;
    assign HTRANS    = {a_valid_reg, 1'b0};
    assign HWRITE    = a_write_reg;
    assign HSIZE     = a_size_reg;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HWDATA    = hwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_error = rsp_error_reg;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomised scoreboard bench for ahb_lite_master with a behavioural AHB slave
// (random wait states, address-selected ERROR responses) and a reference memory.
`timescale 1ns/1ps
module tb_ahb_lite_master;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic        err;
        int          t_acc;
        logic        lat_chk;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } ap_t;

    rsp_t        exp_q[$];
    ap_t         ap_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] slv_mem [256];
    int          checks;
    int          errors;
    int          cyc;
    bit          lat_mode;
    bit          waits_en;
    int          force_wait;

    // slave state
    bit          dp_active, dp_write, dp_err;
    int          dp_waits, err_stage;
    logic [7:0]  dp_idx;
    logic [31:0] dp_wdata;
    logic [1:0]  s_trans, p_trans;
    logic [31:0] s_addr, s_hwdata, p_addr;
    logic        s_ready, s_write, p_ready, p_resp, p_ok;
    logic [2:0]  s_size;
    ap_t         s_ap;
    rsp_t        mon_r;

    // main-stimulus scratch
    logic        r_w;
    logic [2:0]  r_sz;
    logic [31:0] r_a;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    always @(posedge HCLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic bit err_of(input logic [31:0] a);
        return (a[9:8] == 2'b11) || (a == 32'h30);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic accept(input logic w, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd);
        rsp_t       r;
        ap_t        p;
        logic [7:0] idx;
        bit         e;
        idx       = a[9:2];
        e         = err_of(a);
        r.write   = w;
        r.rdata   = w ? 32'h0 : ref_mem[idx];
        r.err     = e;
        r.t_acc   = cyc;
        r.lat_chk = lat_mode;
        if (w && !e) ref_mem[idx] = wd;
        p.addr  = a;
        p.write = w;
        p.size  = sz;
        p.wdata = wd;
        exp_q.push_back(r);
        ap_q.push_back(p);
        $display("cmd  %s addr=%h size=%0d wdata=%h err_expected=%0b",
                 w ? "WR" : "RD", a, sz, wd, e);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd);
        int n;
        bit done;
        n = 0;
        done = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_wdata = wd;
        while (!done) begin
            @(negedge HCLK);
            if (cmd_ready) begin
                accept(w, a, sz, wd);
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_accept_timeout: addr %h not accepted after %0d cycles", a, n);
                    done = 1;
                end
            end
            @(posedge HCLK);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ap_q.size() != 0) && n < 300) begin
            @(posedge HCLK);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d responses pending expected 0", exp_q.size());
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic reset_checks();
        chk("rst_htrans",    32'(HTRANS),    32'h0);
        chk("rst_haddr",     HADDR,          32'h0);
        chk("rst_hwrite",    32'(HWRITE),    32'h0);
        chk("rst_hsize",     32'(HSIZE),     32'h2);
        chk("rst_hwdata",    HWDATA,         32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_error", 32'(rsp_error), 32'h0);
        chk("hburst",        32'(HBURST),    32'h0);
        chk("hprot",         32'(HPROT),     32'h3);
    endtask

    // Behavioural slave: observes the bus at negedge, updates at posedge+1
    initial begin
        HREADY = 1'b1;
        HRESP = 1'b0;
        HRDATA = 32'h0;
        dp_active = 0;
        dp_waits = 0;
        err_stage = 0;
        p_ok = 1'b0;
        p_ready = 1'b1;
        p_resp = 1'b0;
        p_trans = 2'b00;
        p_addr = 32'h0;
        forever begin
            @(negedge HCLK);
            s_trans  = HTRANS;
            s_addr   = HADDR;
            s_write  = HWRITE;
            s_size   = HSIZE;
            s_hwdata = HWDATA;
            s_ready  = HREADY;
            if (HRESETn) begin
                if (p_ok && !p_ready && !p_resp && p_trans == 2'b10) begin
                    chk("hold_htrans", 32'(HTRANS), 32'h2);
                    chk("hold_haddr", HADDR, p_addr);
                end
                if (HREADY && HRESP) chk("err2_htrans_idle", 32'(HTRANS), 32'h0);
                if (!HREADY) chk("cmd_ready_in_wait", 32'(cmd_ready), 32'h0);
            end
            p_ok    = HRESETn;
            p_trans = HTRANS;
            p_addr  = HADDR;
            p_ready = HREADY;
            p_resp  = HRESP;
            @(posedge HCLK);
            #1;
            if (!HRESETn) begin
                dp_active = 0;
                HREADY = 1'b1;
                HRESP = 1'b0;
                p_ok = 1'b0;
                continue;
            end
            if (s_ready && dp_active) begin
                if (dp_write) begin
                    chk("hwdata", s_hwdata, dp_wdata);
                    if (!dp_err) slv_mem[dp_idx] = s_hwdata;
                end
                dp_active = 0;
            end
            if (s_ready && s_trans == 2'b10) begin
                if (ap_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_addr_phase: got haddr %h expected no transfer", s_addr);
                end else begin
                    s_ap = ap_q.pop_front();
                    chk("haddr", s_addr, s_ap.addr);
                    chk("hwrite", 32'(s_write), 32'(s_ap.write));
                    chk("hsize", 32'(s_size), 32'(s_ap.size));
                    dp_active = 1;
                    dp_write  = s_write;
                    dp_idx    = s_addr[9:2];
                    dp_wdata  = s_ap.wdata;
                    dp_err    = err_of(s_addr);
                    err_stage = 0;
                    if (force_wait > 0) dp_waits = force_wait;
                    else if (waits_en) dp_waits = int'($urandom_range(0, 2));
                    else dp_waits = 0;
                end
            end
            if (!dp_active) begin
                HREADY = 1'b1;
                HRESP = 1'b0;
            end else if (dp_waits > 0) begin
                HREADY = 1'b0;
                HRESP = 1'b0;
                dp_waits--;
            end else if (dp_err && err_stage == 0) begin
                HREADY = 1'b0;
                HRESP = 1'b1;
                err_stage = 1;
            end else begin
                HREADY = 1'b1;
                HRESP = dp_err;
            end
            HRDATA = (dp_active && !dp_write) ? slv_mem[dp_idx] : $urandom();
        end
    end

    // Response monitor
    initial begin
        forever begin
            @(negedge HCLK);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata %h err %0b expected no response",
                             rsp_rdata, rsp_error);
                end else begin
                    mon_r = exp_q.pop_front();
                    $display("rsp  %s rdata=%h err=%0b", mon_r.write ? "WR" : "RD", rsp_rdata, rsp_error);
                    chk("rsp_rdata", rsp_rdata, mon_r.rdata);
                    chk("rsp_error", 32'(rsp_error), 32'(mon_r.err));
                    if (mon_r.lat_chk) chk("rsp_latency", 32'(cyc - mon_r.t_acc), 32'd3);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        lat_mode = 0;
        waits_en = 0;
        force_wait = 0;
        HRESETn = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = 32'h0;
        cmd_size = 3'b010;
        cmd_wdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom();
            slv_mem[i] = ref_mem[i];
        end
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        reset_checks();
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // zero-wait: single write, back-to-back reads, then a streaming burst
        lat_mode = 1;
        issue(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        drain();
        issue(1'b0, 32'h10, 3'd2, 32'h0);
        issue(1'b0, 32'h14, 3'd2, 32'h0);
        for (int i = 0; i < 40; i++) begin
            r_w = 1'($urandom_range(0, 1));
            r_a = $urandom_range(32'h40, 32'h2FF) & 32'hFFFF_FFFC;
            issue(r_w, r_a, 3'd2, $urandom());
        end
        drain();
        lat_mode = 0;

        // wait states in the data phase with the next command queued
        force_wait = 3;
        issue(1'b0, 32'h20, 3'd2, 32'h0);
        issue(1'b0, 32'h24, 3'd2, 32'h0);
        drain();
        force_wait = 0;

        // ERROR on a write with a read in address phase
        issue(1'b1, 32'h30, 3'd2, 32'h12345678);
        issue(1'b0, 32'h34, 3'd2, 32'h0);
        drain();

        // randomised traffic with wait states, errors and idle gaps
        waits_en = 1;
        for (int i = 0; i < 300; i++) begin
            r_w  = 1'($urandom_range(0, 1));
            r_sz = 3'($urandom_range(0, 2));
            r_a  = $urandom_range(0, 1023);
            r_a  = r_a & ~((32'd1 << r_sz) - 32'd1);
            issue(r_w, r_a, r_sz, $urandom());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge HCLK);
                #1;
            end
        end
        drain();
        waits_en = 0;

        // asynchronous reset during a wait-stated read
        force_wait = 6;
        issue(1'b0, 32'h80, 3'd2, 32'h0);
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        #2 HRESETn = 1'b0;
        exp_q.delete();
        ap_q.delete();
        #1 reset_checks();
        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        force_wait = 0;
        @(posedge HCLK);
        #1;
        issue(1'b1, 32'h40, 3'd2, 32'hA5A5A5A5);
        issue(1'b0, 32'h40, 3'd2, 32'h0);
        drain();
        chk("post_reset_mem", slv_mem[8'h10], 32'hA5A5A5A5);
        repeat (3) @(posedge HCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
